// File: rtl/tangram_input_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tangram_input_pkg: shared types/constants for button front end   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package tangram_input_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUED    = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } btn_state_e;

    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_U = 2;
    localparam int BTN_D = 3;

    typedef logic [3:0] btn_vec_t;

    localparam int ISSUE_TIMEOUT = 15;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// +------------------------------------------------------------------+
// | button_debounce: 2-FF synchroniser plus stable-level debouncer   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module button_debounce
    import tangram_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNTW            = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic deb_o
);

    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q;
    logic            sync2_q;
    logic            deb_q;
    logic [CNTW-1:0] cnt_q;

    // Counter only advances while the synchronised level disagrees with the
    // accepted level; any agreement restarts the stability window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            if (sync2_q == deb_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                deb_q <= ~deb_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign deb_o = deb_q;

endmodule
`default_nettype wire

// File: rtl/button_trigger_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | button_trigger_gen: debounced buttons -> one-cycle trigger with  |
// | latched vector; BUTTON_AUTO_REPEAT_EN enables hold auto-repeat.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module button_trigger_gen
    import tangram_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 40_000_000,
    parameter int REPEAT_PERIOD   = 5_000_000,
    parameter int CNTW            = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic l_raw,
    input  logic r_raw,
    input  logic u_raw,
    input  logic d_raw,
    input  logic busy,
    output logic trigger,
    output logic l_btn,
    output logic r_btn,
    output logic u_btn,
    output logic d_btn
);

    localparam logic [3:0] WDOG_LAST = 4'(ISSUE_TIMEOUT - 1);

    btn_vec_t raw_vec;
    btn_vec_t pressed;

    assign raw_vec[BTN_L] = l_raw;
    assign raw_vec[BTN_R] = r_raw;
    assign raw_vec[BTN_U] = u_raw;
    assign raw_vec[BTN_D] = d_raw;

    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNTW            (CNTW)
        ) u_debounce (
            .clk   (clk),
            .rst_n (rst_n),
            .raw_i (raw_vec[gi]),
            .deb_o (pressed[gi])
        );
    end

    btn_state_e state_q, state_d;
    btn_vec_t   btn_q, btn_d;
    logic       trigger_q, trigger_d;
    logic [3:0] wdog_q, wdog_d;

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam logic [CNTW-1:0] RPT_FIRST = CNTW'(REPEAT_DELAY);
    localparam logic [CNTW-1:0] RPT_NEXT  = CNTW'(REPEAT_PERIOD);

    logic [CNTW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic            repeat_q, repeat_d;
`endif

    always_comb begin
        state_d   = state_q;
        btn_d     = btn_q;
        trigger_d = 1'b0;
        wdog_d    = '0;
`ifdef BUTTON_AUTO_REPEAT_EN
        rpt_cnt_d = rpt_cnt_q;
        repeat_d  = repeat_q;
`endif
        case (state_q)
            IDLE: begin
                btn_d = '0;
`ifdef BUTTON_AUTO_REPEAT_EN
                repeat_d = 1'b0;
`endif
                if ((pressed != '0) && !busy) begin
                    btn_d     = pressed;
                    trigger_d = 1'b1;
                    state_d   = ISSUED;
                end
            end
            ISSUED: begin
                // Watchdog keeps a consumer that never answers from stalling us.
                wdog_d = wdog_q + 4'd1;
                if (busy || (wdog_q == WDOG_LAST)) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!busy) begin
                    state_d = GAP;
`ifdef BUTTON_AUTO_REPEAT_EN
                    rpt_cnt_d = repeat_q ? RPT_NEXT : RPT_FIRST;
`endif
                end
            end
            GAP: begin
                // Release is checked first so it beats a coincident expiry.
                if (pressed == '0) begin
                    state_d = IDLE;
                    btn_d   = '0;
                end
`ifdef BUTTON_AUTO_REPEAT_EN
                else if (rpt_cnt_q == '0) begin
                    btn_d     = pressed;
                    trigger_d = 1'b1;
                    repeat_d  = 1'b1;
                    state_d   = ISSUED;
                end else begin
                    rpt_cnt_d = rpt_cnt_q - 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                btn_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            btn_q     <= '0;
            trigger_q <= 1'b0;
            wdog_q    <= '0;
`ifdef BUTTON_AUTO_REPEAT_EN
            rpt_cnt_q <= '0;
            repeat_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            btn_q     <= btn_d;
            trigger_q <= trigger_d;
            wdog_q    <= wdog_d;
`ifdef BUTTON_AUTO_REPEAT_EN
            rpt_cnt_q <= rpt_cnt_d;
            repeat_q  <= repeat_d;
`endif
        end
    end

    assign trigger = trigger_q;
    assign l_btn   = btn_q[BTN_L];
    assign r_btn   = btn_q[BTN_R];
    assign u_btn   = btn_q[BTN_U];
    assign d_btn   = btn_q[BTN_D];

endmodule
`default_nettype wire

// File: doc/button_trigger_gen.md
# button_trigger_gen

Input front end for the shape-control stage. Synchronises and debounces the four raw direction buttons, then issues single-cycle `trigger` pulses with the button vector held stable for the whole control operation. Auto-repeats while a button stays held. Sits between the board push-buttons and the square-control block, which consumes `trigger`, `l_btn`/`r_btn`/`u_btn`/`d_btn` and returns `busy`.

## Interface
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable synchronised cycles needed to accept a level change (10 ms at 100 MHz).
- `REPEAT_DELAY`, 40_000_000: cycles from end of first operation to first auto-repeat.
- `REPEAT_PERIOD`, 5_000_000: cycles between subsequent auto-repeats.
- `CNTW`, `$clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)+1)`: counter width.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `l_raw`, `r_raw`, `u_raw`, `d_raw` in 1 each: raw, asynchronous, active-high buttons.
- `busy` in 1: control stage operating.
- `trigger` out 1: one-cycle start pulse to control.
- `l_btn`, `r_btn`, `u_btn`, `d_btn` out 1 each: latched button vector, stable from `trigger` until the next latch.

## Operation
- Each raw input passes through a 2-FF synchroniser.
- Debounce per button: counter clears whenever the synchronised value equals the debounced value. Otherwise it increments. On reaching `DEBOUNCE_CYCLES-1` the debounced value flips and the counter clears.
- `pressed` = 4-bit debounced vector.
- FSM states:
  - IDLE: outputs latch cleared. If `pressed != 0` and `!busy`: latch `pressed`, assert `trigger`, go to ISSUED. If `busy`, wait here.
  - ISSUED: wait for `busy=1`, then go to WAIT_DONE. A 4-bit watchdog runs in this state; at 15 cycles without `busy`, go to WAIT_DONE anyway.
  - WAIT_DONE: latch frozen. When `busy` falls, go to GAP and load the repeat counter.
  - GAP: if `pressed == 0`, go to IDLE (latch cleared). On repeat-counter expiry with `pressed != 0`: latch current `pressed`, pulse `trigger`, go to ISSUED.
- Repeat counter load value:
  - `REPEAT_DELAY` after the first trigger of a press.
  - `REPEAT_PERIOD` after each repeat trigger.
  - A repeat flag, set on the first GAP expiry and cleared in IDLE, selects between the two.
- Multiple buttons are passed through unchanged; priority belongs to the consumer.
- A new press in ISSUED or WAIT_DONE does not change the latch.

## Timing
- Reset values: `trigger=0`, all `*_btn=0`, FSM=IDLE, all counters, synchronisers and debounced values 0.
- Latency:
  - Raw edge to debounced change: 2 + `DEBOUNCE_CYCLES` cycles.
  - Debounced press in IDLE (`busy=0`) to `trigger` high: 1 cycle. `trigger` is registered.
- `trigger` is high for exactly one cycle. The latched outputs change only on the same clock edge that raises `trigger`, or when entering IDLE.
- `busy` is expected 1 cycle after `trigger`.
- GAP expiry: `trigger` fires on the cycle after the counter reaches 0.
- Release and expiry in the same GAP cycle: release wins; go to IDLE with no trigger.
- Asserting `rst_n` low mid-operation forces all reset values immediately, with no trigger on release. Glitches shorter than the debounce window never reach `pressed`.

## Configuration
- `BUTTON_AUTO_REPEAT_EN` defined: auto-repeat as described above.
- Undefined:
  - The repeat counter and flag are not compiled.
  - GAP only waits for `pressed == 0`, then goes to IDLE.
  - Exactly one trigger is produced per press.

## Structure
- Shared package `tangram_input_pkg`:
  - State enum `btn_state_e` (IDLE, ISSUED, WAIT_DONE, GAP).
  - Button index constants `BTN_L=0, BTN_R=1, BTN_U=2, BTN_D=3`.
  - Typedef `btn_vec_t` (`logic [3:0]`).
  - Watchdog limit `ISSUE_TIMEOUT=15`.
- Sub-module `button_debounce` (synchroniser + debounce counter, parameter `DEBOUNCE_CYCLES`), instantiated four times.

## Test plan
Parameters for the bench: `DEBOUNCE_CYCLES=4`, `REPEAT_DELAY=20`, `REPEAT_PERIOD=8`.
- Bounce: `l_raw` toggling every 2 cycles for 20 cycles, then stable high, with `busy=0` -> `trigger` exactly once, 7 cycles after the stable rise; `l_btn=1`, other buttons 0.
- Busy interlock: `busy` held high when `r_raw` becomes debounced -> no trigger until `busy` falls, then `trigger` 1 cycle later; `r_btn` is held through a modelled 10-cycle `busy` pulse.
- Auto-repeat: `u_raw` held, with a `busy` model of 5 cycles -> triggers 21 cycles after `busy` falls, then every 9 cycles after each `busy` fall. Release -> IDLE, `u_btn=0`.
- Release/expiry race: `d_raw` released so that the debounced fall lands on the expiry cycle -> no trigger, FSM returns to IDLE.
- Watchdog: `busy` never asserted -> FSM leaves ISSUED after 15 cycles; the next trigger follows GAP timing.
- Reset mid-WAIT_DONE: `rst_n` low for 1 cycle -> all outputs 0 immediately, FSM in IDLE. With the button still pressed, a new trigger follows after 2 + 4 + 1 cycles.
